stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/clear/lap controller for a mm:ss stopwatch built from two count_60 counters (seconds, minutes).
//  Divides clk into a 1 Hz tick and gates it into the seconds counter's en.
//  Cascades the seconds carry into the minutes counter and issues a synchronous counter clear.
//  Freezes the displayed value on lap; sits between the debounced button pulses and the counter/display path.
// PARAMETERS
//  CLK_DIV  50_000_000  clk cycles per counting tick (>=2); bench uses 4
//  DIV_W    $clog2(CLK_DIV)  localparam, prescaler width (not overridable)
// PORTS
//  clk        in   1  single system clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  btn_start  in   1  1-cycle pulse: start/pause toggle
//  btn_clear  in   1  1-cycle pulse: clear (honoured only when not RUN)
//  btn_lap    in   1  1-cycle pulse: lap freeze/release toggle
//  sec_count  in   7  seconds counter value, 0..59
//  sec_co     in   1  seconds counter carry (value==59)
//  min_count  in   7  minutes counter value, 0..59
//  min_co     in   1  minutes counter carry (value==59)
//  sec_en     out  1  enable to seconds counter, 1-cycle pulse per tick
//  min_en     out  1  enable to minutes counter = sec_en & sec_co
//  cnt_rst    out  1  synchronous clear to both counters, 1-cycle pulse
//  disp_sec   out  7  displayed seconds (live or lap-latched)
//  disp_min   out  7  displayed minutes (live or lap-latched)
//  running    out  1  state==RUN
//  lap_active out  1  display frozen on lap value
//  hour_ovf   out  1  sticky: 59:59 -> 00:00 wrap occurred
// BEHAVIOUR
//  Reset: state IDLE, prescaler 0, lap_active 0, lap regs 0, hour_ovf 0, cnt_rst 0.
//   sec_en/min_en 0; running 0; disp = live inputs.
//  States: IDLE (zeroed, stopped), RUN, PAUSE. Per-cycle priority: clear > start > lap.
//   IDLE:  start -> RUN; clear -> IDLE + cnt_rst; lap ignored.
//   RUN:   start -> PAUSE; clear ignored; lap toggles lap_active.
//   PAUSE: start -> RUN; clear -> IDLE + cnt_rst; lap toggles lap_active.
//  Clear side effects (next edge): prescaler 0, lap_active 0, hour_ovf 0.
//   cnt_rst registered, high exactly 1 cycle.
//  Prescaler: counts only in RUN, wraps CLK_DIV-1 -> 0; holds its value in PAUSE (resume keeps sub-second phase).
//  sec_en = (state==RUN) & (div==CLK_DIV-1), combinational from registers.
//   First sec_en is CLK_DIV cycles after the start-accept edge.
//  Start pulse on the tick cycle in RUN: the tick is still issued (state changes on the same edge).
//  min_en = sec_en & sec_co; counters increment on the edge where en is high.
//  hour_ovf sets on edge where sec_en & sec_co & min_co; cleared only by rst/clear.
//  Lap: on toggle-on, latch sec_count/min_count as presented that cycle (pre-increment).
//   disp_* = lap_active ? lap regs : live inputs (combinational mux).
//  Reset mid-operation: everything returns to reset values on the next edge; no tick is emitted during rst.
// STRUCTURE
//  stopwatch_pkg (shared include): ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2; SEC_MAX=7'd59.
//  Sub-module tick_gen: prescaler with inputs clr/run, output tick; parameter CLK_DIV.
//  Top holds FSM, cnt_rst reg, lap regs, hour_ovf, display mux.
// TESTING (CLK_DIV=4, two real count_60 counters wired to sec_en/min_en/cnt_rst)
//  1 rst, btn_start@c0 -> running=1; sec_en at c4,c8,c12; sec_count 1,2,3.
//  2 Run to div=2, start (pause), idle 20 cycles -> no sec_en.
//   Start again -> sec_en exactly 2 cycles after resume edge.
//  3 Run to 00:59 -> next tick: sec_en=min_en=1, display 01:00.
//   From 59:59 -> 00:00 and hour_ovf=1, stays 1.
//  4 btn_lap at sec_count=5 -> disp_sec=5 while sec_count reaches 8.
//   Second btn_lap -> disp_sec=8 same cycle after edge.
//  5 btn_clear in RUN -> ignored. Pause, then btn_clear -> cnt_rst 1 cycle, counters 0.
//   Result: state IDLE, lap_active=0, hour_ovf=0.
//  6 PAUSE with btn_start+btn_clear same cycle -> IDLE, cnt_rst=1.
//   rst during RUN at div=3 -> no sec_en that cycle; all outputs reset.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and limits for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;
  localparam logic [6:0] SEC_MAX = 7'd59;
endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// tick_gen: prescaler that emits one tick every CLK_DIV cycles while run is high
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  logic [DIV_W-1:0] div;
  // holding div while paused keeps the sub-second phase across resume
  always_ff @(posedge clk)
    if (rst || clr) div <= '0;
    else if (run) div <= (div == DIV_MAX) ? '0 : div + 1'b1;
  assign tick = run & (div == DIV_MAX);
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/lap control and display mux for an mm:ss stopwatch
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [6:0] sec_count,
  input  logic       sec_co,
  input  logic [6:0] min_count,
  input  logic       min_co,
  output logic       sec_en,
  output logic       min_en,
  output logic       cnt_rst,
  output logic [6:0] disp_sec,
  output logic [6:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       hour_ovf
);
  state_t state, nxt;
  logic clr_acc, lap_tgl, tick;
  logic [6:0] lap_sec, lap_min;
  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr_acc),
    .run (running),
    .tick(tick)
  );
  // one button acts per cycle: clear (outside RUN) beats start beats lap
  always_comb begin
    nxt = state;
    clr_acc = 1'b0;
    lap_tgl = 1'b0;
    if (btn_clear && state != ST_RUN) begin
      nxt = ST_IDLE;
      clr_acc = 1'b1;
    end else if (btn_start) nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    else lap_tgl = btn_lap && state != ST_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      cnt_rst <= 1'b0;
      lap_active <= 1'b0;
      lap_sec <= '0;
      lap_min <= '0;
      hour_ovf <= 1'b0;
    end else begin
      state <= nxt;
      cnt_rst <= clr_acc;
      lap_active <= clr_acc ? 1'b0 : lap_active ^ lap_tgl;
      if (lap_tgl && !lap_active) begin
        lap_sec <= sec_count;
        lap_min <= min_count;
      end
      hour_ovf <= clr_acc ? 1'b0 : hour_ovf | (min_en & min_co);
    end
  assign running = state == ST_RUN;
  assign sec_en = tick & ~rst;
  assign min_en = sec_en & sec_co;
  assign disp_sec = lap_active ? lap_sec : sec_count;
  assign disp_min = lap_active ? lap_min : min_count;
endmodule
